// File: rtl/puf_frame_pkg.sv
// ---------------------------------------------------------------------------
// puf_frame_pkg
// Shared definitions for the PUF UART framing controller:
//   - frame_state_e : controller FSM states
//   - DEFAULT_*     : default command / reply byte values and sizes
// Optional feature macro used by the controller: RX_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package puf_frame_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CHAL_RX    = 3'd1,
        RESP_WAIT  = 3'd2,
        RESP_FETCH = 3'd3,
        TX_SEND    = 3'd4,
        TX_WAIT    = 3'd5
    } frame_state_e;

    localparam int         DEFAULT_UART_BITS   = 8;
    localparam int         DEFAULT_CHAL_BYTES  = 4;
    localparam int         DEFAULT_RESP_BYTES  = 2;
    localparam logic [7:0] DEFAULT_REQUEST_ID  = 8'hAA;
    localparam logic [7:0] DEFAULT_RESPONSE_ID = 8'hAA;
    localparam logic [7:0] DEFAULT_CHAL_CMD    = 8'h55;

endpackage

// File: rtl/puf_challenge_assembler.sv
// ---------------------------------------------------------------------------
// puf_challenge_assembler
// Collects CHAL_BYTES received bytes into one wide challenge word. Byte k of
// a frame lands at bits [k*UART_BITS +: UART_BITS] (first byte lowest). When
// the last byte arrives the assembled word is copied to challenge_o and
// done_o pulses for one cycle, both visible the cycle after that byte.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   clear_i       restart assembly (new frame or aborted frame)
//   byte_valid_i  byte_i carries the next challenge byte
//   byte_i        received byte
//   last_byte_o   combinational: the current byte completes the challenge
//   challenge_o   last completed challenge word
//   done_o        one-cycle pulse, challenge_o just updated
// ---------------------------------------------------------------------------
module puf_challenge_assembler #(
    parameter int UART_BITS  = 8,
    parameter int CHAL_BYTES = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear_i,
    input  logic                            byte_valid_i,
    input  logic [UART_BITS-1:0]            byte_i,
    output logic                            last_byte_o,
    output logic [CHAL_BYTES*UART_BITS-1:0] challenge_o,
    output logic                            done_o
);

    localparam int CHAL_W = CHAL_BYTES * UART_BITS;
    localparam int CNT_W  = $clog2(CHAL_BYTES + 1);

    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [CHAL_W-1:0] asm_q, asm_d;
    logic [CHAL_W-1:0] challenge_q, challenge_d;
    logic              done_q, done_d;

    // Kept separate from the next-state block so the controller can use it
    // without forming a combinational loop through clear_i.
    assign last_byte_o = byte_valid_i && (byte_cnt_q == CNT_W'(CHAL_BYTES - 1));

    // The counter parks at CHAL_BYTES after a full frame instead of wrapping;
    // only clear_i rearms it.
    always_comb begin
        asm_d       = asm_q;
        byte_cnt_d  = byte_cnt_q;
        challenge_d = challenge_q;
        done_d      = 1'b0;
        if (clear_i) begin
            asm_d      = '0;
            byte_cnt_d = '0;
        end else if (byte_valid_i && (byte_cnt_q != CNT_W'(CHAL_BYTES))) begin
            for (int k = 0; k < CHAL_BYTES; k++) begin
                if (byte_cnt_q == CNT_W'(k)) begin
                    asm_d[k*UART_BITS +: UART_BITS] = byte_i;
                end
            end
            if (last_byte_o) begin
                challenge_d = asm_d;
                done_d      = 1'b1;
                byte_cnt_d  = CNT_W'(CHAL_BYTES);
            end else begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q       <= '0;
            byte_cnt_q  <= '0;
            challenge_q <= '0;
            done_q      <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            byte_cnt_q  <= byte_cnt_d;
            challenge_q <= challenge_d;
            done_q      <= done_d;
        end
    end

    assign challenge_o = challenge_q;
    assign done_o      = done_q;

endmodule

// File: rtl/puf_frame_controller.sv
// ---------------------------------------------------------------------------
// puf_frame_controller
// UART framing controller between the UART rx/tx pair, the PUF core and the
// response FIFO. Decodes one-byte commands: REQUEST_ID is answered with
// RESPONSE_ID, CHAL_CMD opens a CHAL_BYTES-byte challenge frame which is then
// answered by streaming RESP_BYTES bytes from the FIFO to UART tx. Any other
// command byte in IDLE raises frame_error.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   rx_data_in       received byte, qualified by rx_valid (1-cycle pulse)
//   tx_data_out      registered byte to UART tx, stable between loads
//   tx_start         1-cycle pulse launching a transmission
//   tx_busy          UART tx busy (rises the cycle after tx_start)
//   fifo_out         FIFO head, valid one cycle after fifo_rd
//   fifo_empty       FIFO empty flag
//   fifo_rd          1-cycle FIFO pop
//   challenge        last assembled challenge word
//   challenge_valid  1-cycle pulse, challenge updated
//   id_requested     1-cycle pulse on REQUEST_ID decode
//   frame_error      1-cycle pulse on unknown command or inter-byte timeout
//
// Optional feature: define RX_TIMEOUT_EN to abort a challenge frame when no
// byte arrives for TIMEOUT_CYCLES cycles. Without it CHAL_RX waits forever.
// ---------------------------------------------------------------------------
module puf_frame_controller
    import puf_frame_pkg::*;
#(
    parameter int                   UART_BITS      = DEFAULT_UART_BITS,
    parameter int                   CHAL_BYTES     = DEFAULT_CHAL_BYTES,
    parameter int                   RESP_BYTES     = DEFAULT_RESP_BYTES,
    parameter logic [UART_BITS-1:0] REQUEST_ID     = UART_BITS'(DEFAULT_REQUEST_ID),
    parameter logic [UART_BITS-1:0] RESPONSE_ID    = UART_BITS'(DEFAULT_RESPONSE_ID),
    parameter logic [UART_BITS-1:0] CHAL_CMD       = UART_BITS'(DEFAULT_CHAL_CMD),
    parameter int                   TIMEOUT_CYCLES = 100000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [UART_BITS-1:0]            rx_data_in,
    input  logic                            rx_valid,
    output logic [UART_BITS-1:0]            tx_data_out,
    output logic                            tx_start,
    input  logic                            tx_busy,
    input  logic [UART_BITS-1:0]            fifo_out,
    input  logic                            fifo_empty,
    output logic                            fifo_rd,
    output logic [CHAL_BYTES*UART_BITS-1:0] challenge,
    output logic                            challenge_valid,
    output logic                            id_requested,
    output logic                            frame_error
);

    localparam int RESP_CNT_W = $clog2(RESP_BYTES + 1);

    frame_state_e           state_q, state_d;
    logic [UART_BITS-1:0]   tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   id_req_q, id_req_d;
    logic                   frame_err_q, frame_err_d;
    logic                   reply_id_q, reply_id_d;
    logic [RESP_CNT_W-1:0]  resp_cnt_q, resp_cnt_d;

    logic                   chal_clear;
    logic                   chal_byte_valid;
    logic                   chal_last;
    logic                   tmo_hit;

    assign chal_byte_valid = (state_q == CHAL_RX) && rx_valid;

    puf_challenge_assembler #(
        .UART_BITS  (UART_BITS),
        .CHAL_BYTES (CHAL_BYTES)
    ) u_assembler (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (chal_clear),
        .byte_valid_i (chal_byte_valid),
        .byte_i       (rx_data_in),
        .last_byte_o  (chal_last),
        .challenge_o  (challenge),
        .done_o       (challenge_valid)
    );

`ifdef RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Idle-cycle counter for CHAL_RX; any received byte restarts it and it
    // sits at zero in every other state.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if ((state_q == CHAL_RX) && !rx_valid) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign tmo_hit            = 1'b0;
`endif

    // Frame FSM. fifo_rd is combinational so the FIFO head is ready exactly
    // when RESP_FETCH samples it; all other outputs are registered pulses.
    // In TX_WAIT the cycle carrying tx_start is always skipped because the
    // UART only raises tx_busy one cycle later.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        id_req_d    = 1'b0;
        frame_err_d = 1'b0;
        reply_id_d  = reply_id_q;
        resp_cnt_d  = resp_cnt_q;
        fifo_rd     = 1'b0;
        chal_clear  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data_in == REQUEST_ID) begin
                        id_req_d   = 1'b1;
                        tx_data_d  = RESPONSE_ID;
                        reply_id_d = 1'b1;
                        state_d    = TX_SEND;
                    end else if (rx_data_in == CHAL_CMD) begin
                        chal_clear = 1'b1;
                        state_d    = CHAL_RX;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            CHAL_RX: begin
                if (chal_last) begin
                    resp_cnt_d = '0;
                    reply_id_d = 1'b0;
                    state_d    = RESP_WAIT;
                end else if (tmo_hit) begin
                    frame_err_d = 1'b1;
                    chal_clear  = 1'b1;
                    state_d     = IDLE;
                end
            end

            RESP_WAIT: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    state_d = RESP_FETCH;
                end
            end

            RESP_FETCH: begin
                tx_data_d = fifo_out;
                state_d   = TX_SEND;
            end

            TX_SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = TX_WAIT;
                end
            end

            TX_WAIT: begin
                if (!tx_start_q && !tx_busy) begin
                    if (reply_id_q) begin
                        reply_id_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        resp_cnt_d = resp_cnt_q + RESP_CNT_W'(1);
                        if (resp_cnt_d == RESP_CNT_W'(RESP_BYTES)) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RESP_WAIT;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            id_req_q    <= 1'b0;
            frame_err_q <= 1'b0;
            reply_id_q  <= 1'b0;
            resp_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            id_req_q    <= id_req_d;
            frame_err_q <= frame_err_d;
            reply_id_q  <= reply_id_d;
            resp_cnt_q  <= resp_cnt_d;
        end
    end

    assign tx_data_out  = tx_data_q;
    assign tx_start     = tx_start_q;
    assign id_requested = id_req_q;
    assign frame_error  = frame_err_q;

endmodule

// File: tb/tb_puf_frame_controller.sv
// ---------------------------------------------------------------------------
// tb_puf_frame_controller
// Directed bench for puf_frame_controller with a small FIFO model and a UART
// tx model that stays busy for 10 cycles after every tx_start.
// Define RX_TIMEOUT_EN to include the inter-byte timeout scenario
// (TIMEOUT_CYCLES = 50 in that build).
// ---------------------------------------------------------------------------
module tb_puf_frame_controller;

`ifdef RX_TIMEOUT_EN
    localparam int TB_TIMEOUT   = 50;
    localparam int EXP_FE_COUNT = 3;
`else
    localparam int TB_TIMEOUT   = 100000;
    localparam int EXP_FE_COUNT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data_in;
    logic        rx_valid;
    logic [7:0]  tx_data_out;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  fifo_out = 8'h00;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [31:0] challenge;
    logic        challenge_valid;
    logic        id_requested;
    logic        frame_error;

    int testsRun    = 0;
    int testsFailed = 0;

    puf_frame_controller #(
        .UART_BITS      (8),
        .CHAL_BYTES     (4),
        .RESP_BYTES     (2),
        .REQUEST_ID     (8'hAA),
        .RESPONSE_ID    (8'hAA),
        .CHAL_CMD       (8'h55),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data_in      (rx_data_in),
        .rx_valid        (rx_valid),
        .tx_data_out     (tx_data_out),
        .tx_start        (tx_start),
        .tx_busy         (tx_busy),
        .fifo_out        (fifo_out),
        .fifo_empty      (fifo_empty),
        .fifo_rd         (fifo_rd),
        .challenge       (challenge),
        .challenge_valid (challenge_valid),
        .id_requested    (id_requested),
        .frame_error     (frame_error)
    );

    always #5 clk = ~clk;

    // FIFO model: head appears on fifo_out the cycle after fifo_rd.
    logic [7:0] fifoMem [0:7];
    int fifoWr = 0;
    int fifoRd = 0;
    assign fifo_empty = (fifoRd == fifoWr);

    always @(posedge clk) begin
        if (fifo_rd && (fifoRd != fifoWr)) begin
            fifo_out <= fifoMem[fifoRd];
            fifoRd   <= fifoRd + 1;
        end
    end

    // UART tx model: busy for 10 cycles starting the cycle after tx_start,
    // plus an override the stimulus can hold high.
    int   busyCnt   = 0;
    logic forceBusy = 1'b0;
    assign tx_busy = (busyCnt != 0) || forceBusy;

    always @(posedge clk) begin
        if (tx_start) begin
            busyCnt <= 10;
        end else if (busyCnt > 0) begin
            busyCnt <= busyCnt - 1;
        end
    end

    // Monitor: log transmitted bytes and count the single-cycle pulses.
    logic [7:0] txLog [0:7];
    int txCount      = 0;
    int idCount      = 0;
    int cvCount      = 0;
    int feCount      = 0;
    int rdCount      = 0;
    int overlapCount = 0;

    always @(posedge clk) begin
        if (tx_start && (txCount < 8)) begin
            txLog[txCount] <= tx_data_out;
            txCount        <= txCount + 1;
        end
        if (id_requested)    idCount <= idCount + 1;
        if (challenge_valid) cvCount <= cvCount + 1;
        if (frame_error)     feCount <= feCount + 1;
        if (fifo_rd)         rdCount <= rdCount + 1;
        if ((int'(id_requested) + int'(challenge_valid) + int'(frame_error)) > 1) begin
            overlapCount <= overlapCount + 1;
        end
    end

    // Drives one byte for exactly one cycle; call at a falling edge, returns
    // at the falling edge after the byte was sampled.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data_in = b;
        rx_valid   = 1'b1;
        @(negedge clk);
        rx_valid   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        reset      = 1'b1;
        rx_data_in = 8'h00;
        rx_valid   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("reset_tx_start",   64'(tx_start),        64'h0);
        checkOutput("reset_tx_data",    64'(tx_data_out),     64'h0);
        checkOutput("reset_fifo_rd",    64'(fifo_rd),         64'h0);
        checkOutput("reset_challenge",  64'(challenge),       64'h0);
        checkOutput("reset_chal_valid", 64'(challenge_valid), 64'h0);
        checkOutput("reset_id_req",     64'(id_requested),    64'h0);
        checkOutput("reset_frame_err",  64'(frame_error),     64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Identification request; 8'h55 sent during TX_WAIT must be ignored
        applyStimulus(8'hAA);
        checkOutput("id_pulse",          64'(id_requested), 64'h1);
        checkOutput("id_no_frame_error", 64'(frame_error),  64'h0);
        checkOutput("id_tx_data",        64'(tx_data_out),  64'hAA);
        @(negedge clk);
        checkOutput("id_pulse_ends",     64'(id_requested), 64'h0);
        checkOutput("id_tx_start",       64'(tx_start),     64'h1);
        applyStimulus(8'h55);
        repeat (15) @(negedge clk);
        checkOutput("id_tx_count",       64'(txCount),      64'd1);
        checkOutput("id_tx_byte",        64'(txLog[0]),     64'hAA);

        // Unknown command in IDLE
        applyStimulus(8'h77);
        checkOutput("bad_cmd_frame_error", 64'(frame_error),  64'h1);
        checkOutput("bad_cmd_no_id",       64'(id_requested), 64'h0);
        @(negedge clk);
        checkOutput("bad_cmd_pulse_ends",  64'(frame_error),  64'h0);
        repeat (4) @(negedge clk);
        checkOutput("bad_cmd_no_tx",       64'(txCount),      64'd1);

        // Challenge frame with two FIFO response bytes, tx held busy first
        fifoMem[0] = 8'h3C;
        fifoMem[1] = 8'hC3;
        fifoWr     = 2;
        forceBusy  = 1'b1;
        applyStimulus(8'h55);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        checkOutput("chal_partial_hidden", 64'(challenge),       64'h0);
        checkOutput("chal_partial_novld",  64'(challenge_valid), 64'h0);
        applyStimulus(8'h04);
        checkOutput("chal_word",           64'(challenge),       64'h04030201);
        checkOutput("chal_valid",          64'(challenge_valid), 64'h1);
        checkOutput("chal_fifo_rd",        64'(fifo_rd),         64'h1);
        @(negedge clk);
        checkOutput("chal_valid_ends",     64'(challenge_valid), 64'h0);
        checkOutput("fetch_no_rd",         64'(fifo_rd),         64'h0);
        checkOutput("fetch_tx_data_hold",  64'(tx_data_out),     64'hAA);
        @(negedge clk);
        checkOutput("fetch_tx_data_load",  64'(tx_data_out),     64'h3C);
        repeat (10) @(negedge clk);
        checkOutput("busy_blocks_start",   64'(txCount),         64'd1);
        forceBusy = 1'b0;
        @(negedge clk);
        checkOutput("resp0_tx_start",      64'(tx_start),        64'h1);
        waited = 0;
        while ((txCount < 3) && (waited < 200)) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("resp_tx_count",       64'(txCount),         64'd3);
        checkOutput("resp_byte0",          64'(txLog[1]),        64'h3C);
        checkOutput("resp_byte1",          64'(txLog[2]),        64'hC3);
        repeat (20) @(negedge clk);
        checkOutput("resp_fifo_reads",     64'(rdCount),         64'd2);
        checkOutput("resp_no_extra_tx",    64'(txCount),         64'd3);

`ifdef RX_TIMEOUT_EN
        // Inter-byte timeout after two challenge bytes
        applyStimulus(8'h55);
        applyStimulus(8'h09);
        applyStimulus(8'h08);
        waited = 0;
        while (!frame_error && (waited < 80)) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("tmo_frame_error",     64'(frame_error),     64'h1);
        checkOutput("tmo_latency",         64'(waited),          64'd50);
        checkOutput("tmo_chal_unchanged",  64'(challenge),       64'h04030201);
        checkOutput("tmo_no_chal_valid",   64'(challenge_valid), 64'h0);
        @(negedge clk);
        applyStimulus(8'h77);
        checkOutput("tmo_back_in_idle",    64'(frame_error),     64'h1);
        @(negedge clk);
`endif

        // Reset in the middle of a challenge frame
        applyStimulus(8'h55);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        reset = 1'b1;
        #1;
        checkOutput("midrst_challenge",    64'(challenge),       64'h0);
        checkOutput("midrst_tx_data",      64'(tx_data_out),     64'h0);
        checkOutput("midrst_tx_start",     64'(tx_start),        64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(8'h55);
        applyStimulus(8'hA1);
        applyStimulus(8'hB2);
        applyStimulus(8'hC3);
        applyStimulus(8'hD4);
        checkOutput("fresh_chal_word",     64'(challenge),       64'hD4C3B2A1);
        checkOutput("fresh_chal_valid",    64'(challenge_valid), 64'h1);
        checkOutput("empty_fifo_no_rd",    64'(fifo_rd),         64'h0);
        @(negedge clk);
        applyStimulus(8'h77);
        checkOutput("resp_wait_rx_drop",   64'(frame_error),     64'h0);
        repeat (3) @(negedge clk);

        // Totals over the whole run
        checkOutput("total_id_pulses",     64'(idCount),         64'd1);
        checkOutput("total_chal_valid",    64'(cvCount),         64'd2);
        checkOutput("total_frame_errors",  64'(feCount),         64'(EXP_FE_COUNT));
        checkOutput("pulse_exclusive",     64'(overlapCount),    64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
